// File: rtl/uart_pkg.sv
// Shared types for the UART command receiver: command codes, receiver states
// and the ASCII key map used to turn keystrokes into game commands.
`timescale 1ns/1ps
package uart_pkg;

  typedef enum logic [2:0] {
    CMD_LEFT, CMD_RIGHT, CMD_DOWN, CMD_ROTATE,
    CMD_DROP, CMD_HOLD, CMD_PAUSE, CMD_RESTART
  } cmd_t;

  typedef enum logic [2:0] {
    ST_IDLE, ST_START, ST_DATA, ST_STOP, ST_BREAK
  } rx_state_t;

  typedef struct packed {
    logic hit;
    cmd_t code;
  } key_dec_t;

  localparam logic [7:0] KEY_A_LO = 8'h61, KEY_A_UP = 8'h41;
  localparam logic [7:0] KEY_D_LO = 8'h64, KEY_D_UP = 8'h44;
  localparam logic [7:0] KEY_S_LO = 8'h73, KEY_S_UP = 8'h53;
  localparam logic [7:0] KEY_W_LO = 8'h77, KEY_W_UP = 8'h57;
  localparam logic [7:0] KEY_SPACE = 8'h20;
  localparam logic [7:0] KEY_C_LO = 8'h63, KEY_C_UP = 8'h43;
  localparam logic [7:0] KEY_P_LO = 8'h70, KEY_P_UP = 8'h50;
  localparam logic [7:0] KEY_R_LO = 8'h72, KEY_R_UP = 8'h52;

  // Bytes outside the key map return hit=0 and must not reach the buffer.
  function automatic key_dec_t decode_key(input logic [7:0] ch);
    key_dec_t d;
    d.hit  = 1'b1;
    d.code = CMD_LEFT;
    case (ch)
      KEY_A_LO, KEY_A_UP: d.code = CMD_LEFT;
      KEY_D_LO, KEY_D_UP: d.code = CMD_RIGHT;
      KEY_S_LO, KEY_S_UP: d.code = CMD_DOWN;
      KEY_W_LO, KEY_W_UP: d.code = CMD_ROTATE;
      KEY_SPACE:          d.code = CMD_DROP;
      KEY_C_LO, KEY_C_UP: d.code = CMD_HOLD;
      KEY_P_LO, KEY_P_UP: d.code = CMD_PAUSE;
      KEY_R_LO, KEY_R_UP: d.code = CMD_RESTART;
      default:            d.hit  = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 deserialiser: two-flop synchroniser, mid-bit sampling FSM and
// registered byte/frame-error pulses.
`timescale 1ns/1ps
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 115200
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       uart_rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err
);

  localparam int DIV  = CLK_HZ / BAUD;
  localparam int HALF = DIV / 2;
  localparam int CW   = $clog2(DIV + 1);
  localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);

  logic          rx_meta;
  logic          rxs;
  rx_state_t     state;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    shift;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rxs     <= rx_meta;
    end
  end

  // After the half-bit start check, every later sample lands mid-bit DIV cycles apart.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      idx       <= '0;
      shift     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!rxs) begin
            cnt   <= '0;
            state <= ST_START;
          end
        end
        ST_START: begin
          if (cnt == HALF_LAST) begin
            cnt <= '0;
            idx <= '0;
            state <= rxs ? ST_IDLE : ST_DATA;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_DATA: begin
          if (cnt == DIV_LAST) begin
            cnt        <= '0;
            shift[idx] <= rxs;
            idx        <= idx + 3'd1;
            if (idx == 3'd7) state <= ST_STOP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_STOP: begin
          if (cnt == DIV_LAST) begin
            cnt <= '0;
            if (rxs) begin
              rx_data  <= shift;
              rx_valid <= 1'b1;
              state    <= ST_IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= ST_BREAK;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        // A line held low reports once, then waits for idle before re-arming.
        ST_BREAK: begin
          if (rxs) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_cmd_rx.sv
// UART key receiver: decodes received bytes into game commands and holds
// them in a one-deep valid/ready buffer for the game logic.
`timescale 1ns/1ps
module uart_cmd_rx
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 115200
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       uart_rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic [2:0] cmd,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic       cmd_overrun
);

  key_dec_t dec;
  logic     new_cmd;
  logic     accept;

  uart_rx_core #(
    .CLK_HZ (CLK_HZ),
    .BAUD   (BAUD)
  ) u_core (
    .clk       (clk),
    .reset_n   (reset_n),
    .uart_rx   (uart_rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err)
  );

  always_comb begin
    dec     = decode_key(rx_data);
    new_cmd = rx_valid & dec.hit;
    accept  = cmd_valid & cmd_ready;
  end

  // A slot freed by this cycle's handshake can take the new command immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmd         <= '0;
      cmd_valid   <= 1'b0;
      cmd_overrun <= 1'b0;
    end else begin
      cmd_overrun <= 1'b0;
      if (new_cmd) begin
        if (!cmd_valid || cmd_ready) begin
          cmd       <= dec.code;
          cmd_valid <= 1'b1;
        end else begin
          cmd_overrun <= 1'b1;
        end
      end else if (accept) begin
        cmd_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Self-checking bench for uart_cmd_rx: directed frames plus a per-cycle
// comparison against a frame queue and command-buffer model.
`timescale 1ns/1ps
module tb_uart_cmd_rx;

  localparam int CLK_HZ  = 50_000_000;
  localparam int BAUD    = 115200;
  localparam int DIV     = CLK_HZ / BAUD;
  localparam int HALF    = DIV / 2;
  localparam int EXP_LAT = 9 * DIV + HALF;
  localparam int LAT_TOL = 6;
  localparam int GAP     = 40;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       uart_rx = 1'b1;
  logic       cmd_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic [2:0] cmd;
  logic       cmd_valid;
  logic       cmd_overrun;

  typedef struct {
    logic [7:0] data;
    bit         good;
    int         due;
  } frame_t;

  frame_t     exp_q[$];
  int         tests = 0;
  int         fails = 0;
  int         cyc = 0;
  int         n_rx_valid = 0, n_ferr = 0, n_ovr = 0, n_cmdv = 0;
  logic [7:0] m_data = 8'h00;
  logic [2:0] m_cmd = 3'd0;
  bit         m_valid = 1'b0;
  bit         m_ovr = 1'b0;

  uart_cmd_rx #(
    .CLK_HZ (CLK_HZ),
    .BAUD   (BAUD)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .uart_rx     (uart_rx),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .frame_err   (frame_err),
    .cmd         (cmd),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_overrun (cmd_overrun)
  );

  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp_v);
    tests++;
    if (act !== exp_v) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  // Key map as a lookup string: lowercase letters by command number, space is DROP.
  function automatic void model_key(input logic [7:0] b, output bit hit, output logic [2:0] code);
    string      keys;
    logic [7:0] lc;
    keys = "adsw cpr";
    lc   = (b >= 8'h41 && b <= 8'h5A) ? b + 8'd32 : b;
    hit  = 1'b0;
    code = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (keys[i] == lc) begin
        hit  = 1'b1;
        code = 3'(i);
      end
    end
  endfunction

  always @(negedge clk) begin
    frame_t     f;
    bit         hit;
    bit         nhit;
    logic [2:0] code;
    if (!reset_n) begin
      checkOutput("reset_outputs",
                  {rx_valid, frame_err, cmd_valid, cmd_overrun, 1'b0, cmd}, 8'h00);
      checkOutput("reset_rx_data", rx_data, 8'h00);
      m_data  = 8'h00;
      m_cmd   = 3'd0;
      m_valid = 1'b0;
      m_ovr   = 1'b0;
    end else begin
      nhit = 1'b0;
      code = 3'd0;
      checkOutput("pulse_exclusive", {7'd0, rx_valid & frame_err}, 8'h00);
      if (rx_valid || frame_err) begin
        if (exp_q.size() == 0) begin
          checkOutput(rx_valid ? "unexpected_rx_valid" : "unexpected_frame_err", 8'h01, 8'h00);
        end else begin
          f = exp_q.pop_front();
          checkOutput("frame_kind", {7'd0, rx_valid}, {7'd0, f.good});
          checkOutput("frame_latency",
                      {7'd0, ((cyc - f.due) >= -LAT_TOL) && ((cyc - f.due) <= LAT_TOL)}, 8'h01);
          if (f.good && rx_valid) begin
            m_data = f.data;
            model_key(f.data, hit, code);
            nhit = hit;
          end
        end
      end
      checkOutput("rx_data", rx_data, m_data);
      checkOutput("cmd_valid", {7'd0, cmd_valid}, {7'd0, m_valid});
      checkOutput("cmd", {5'd0, cmd}, {5'd0, m_cmd});
      checkOutput("cmd_overrun", {7'd0, cmd_overrun}, {7'd0, m_ovr});
      if (rx_valid)    n_rx_valid++;
      if (frame_err)   n_ferr++;
      if (cmd_overrun) n_ovr++;
      if (cmd_valid)   n_cmdv++;
      m_ovr = 1'b0;
      if (nhit) begin
        if (!m_valid || cmd_ready) begin
          m_cmd   = code;
          m_valid = 1'b1;
        end else begin
          m_ovr = 1'b1;
        end
      end else if (m_valid && cmd_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Leaves the line at the stop level; a low stop is released by the caller.
  task automatic applyStimulus(input logic [7:0] b, input bit stop_bit);
    exp_q.push_back('{data: b, good: stop_bit, due: cyc + EXP_LAT});
    uart_rx = 1'b0;
    tick(DIV);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      tick(DIV);
    end
    uart_rx = stop_bit;
    tick(DIV);
    if (stop_bit) tick(GAP);
  endtask

  task automatic sendAborted(input logic [7:0] b, input int bits_sent);
    uart_rx = 1'b0;
    tick(DIV);
    for (int i = 0; i < bits_sent; i++) begin
      uart_rx = b[i];
      tick(DIV);
    end
    uart_rx = b[bits_sent];
    tick(DIV / 2);
    reset_n = 1'b0;
    uart_rx = 1'b1;
    tick(10);
    reset_n = 1'b1;
    tick(GAP);
  endtask

  initial begin
    int b_rv, b_fe, b_ov, b_cv;
    #1 reset_n = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("por_cmd_valid", {7'd0, cmd_valid}, 8'h00);
    reset_n = 1'b1;
    tick(20);

    $display("[TB] 'a' with consumer ready");
    cmd_ready = 1'b1;
    b_cv = n_cmdv;
    applyStimulus(8'h61, 1'b1);
    checkOutput("a_rx_data", rx_data, 8'h61);
    checkOutput("a_cmd", {5'd0, cmd}, 8'h00);
    checkOutput("a_cmd_valid_cycles", 8'(n_cmdv - b_cv), 8'h01);

    $display("[TB] start-bit glitch then 'd'");
    b_rv = n_rx_valid; b_fe = n_ferr;
    uart_rx = 1'b0;
    tick(100);
    uart_rx = 1'b1;
    tick(HALF + 400);
    checkOutput("glitch_rx_valid", 8'(n_rx_valid - b_rv), 8'h00);
    checkOutput("glitch_frame_err", 8'(n_ferr - b_fe), 8'h00);
    applyStimulus(8'h64, 1'b1);
    checkOutput("d_cmd", {5'd0, cmd}, 8'h01);

    $display("[TB] 0x77 with low stop and held break, then space");
    b_rv = n_rx_valid; b_fe = n_ferr; b_cv = n_cmdv;
    applyStimulus(8'h77, 1'b0);
    tick(2000);
    uart_rx = 1'b1;
    tick(GAP);
    checkOutput("break_frame_err_count", 8'(n_ferr - b_fe), 8'h01);
    checkOutput("break_rx_valid_count", 8'(n_rx_valid - b_rv), 8'h00);
    checkOutput("break_cmd_valid_count", 8'(n_cmdv - b_cv), 8'h00);
    applyStimulus(8'h20, 1'b1);
    checkOutput("space_cmd", {5'd0, cmd}, 8'h04);

    $display("[TB] stalled consumer: 's' then 'w'");
    cmd_ready = 1'b0;
    b_ov = n_ovr;
    tick(5);
    applyStimulus(8'h73, 1'b1);
    applyStimulus(8'h77, 1'b1);
    checkOutput("stall_cmd", {5'd0, cmd}, 8'h02);
    checkOutput("stall_cmd_valid", {7'd0, cmd_valid}, 8'h01);
    checkOutput("stall_overrun_count", 8'(n_ovr - b_ov), 8'h01);
    cmd_ready = 1'b1;
    tick(1);
    checkOutput("release_cmd_valid", {7'd0, cmd_valid}, 8'h00);
    checkOutput("release_cmd_kept", {5'd0, cmd}, 8'h02);

    $display("[TB] unmapped byte 'z'");
    b_rv = n_rx_valid; b_ov = n_ovr; b_cv = n_cmdv;
    applyStimulus(8'h7A, 1'b1);
    checkOutput("z_rx_data", rx_data, 8'h7A);
    checkOutput("z_rx_valid_count", 8'(n_rx_valid - b_rv), 8'h01);
    checkOutput("z_cmd_valid_count", 8'(n_cmdv - b_cv), 8'h00);
    checkOutput("z_overrun_count", 8'(n_ovr - b_ov), 8'h00);

    $display("[TB] reset during data bit 4, then 'P'");
    cmd_ready = 1'b0;
    b_rv = n_rx_valid; b_fe = n_ferr;
    sendAborted(8'h50, 4);
    applyStimulus(8'h50, 1'b1);
    checkOutput("p_cmd", {5'd0, cmd}, 8'h06);
    checkOutput("p_cmd_valid", {7'd0, cmd_valid}, 8'h01);
    checkOutput("p_rx_valid_count", 8'(n_rx_valid - b_rv), 8'h01);
    checkOutput("p_frame_err_count", 8'(n_ferr - b_fe), 8'h00);

    tick(10);
    checkOutput("frames_outstanding", 8'(exp_q.size()), 8'h00);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
